// File: rtl/counter_timeslot_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : counter_timeslot_arbiter_if
// Purpose  : Request/grant and counter status bundle for the timeslot arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface counter_timeslot_arbiter_if #(
    parameter int NREQ = 4,
    parameter int CW   = 4
);
    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] len;
    logic               tick_en;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic               busy;
    logic [CW-1:0]      cnt_q;

    modport master (
        output req, len, tick_en,
        input  gnt, done, busy, cnt_q
    );

    modport slave (
        input  req, len, tick_en,
        output gnt, done, busy, cnt_q
    );
endinterface
`default_nettype wire

// File: rtl/counter_timeslot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : counter_timeslot_arbiter
// Purpose  : Round-robin sharing of one CW-bit tick counter among NREQ clients.
// Revision : 1.0 - initial release
// ============================================================================
module counter_timeslot_arbiter #(
    parameter int NREQ = 4,
    parameter int CW   = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    counter_timeslot_arbiter_if.slave  bus
);
    localparam int            IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] C_ONE = NREQ'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [NREQ-1:0] r_gnt, w_gnt_nxt;
    logic [NREQ-1:0] r_done, w_done_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [CW-1:0]   r_target, w_target_nxt;
    logic [IW-1:0]   r_win, w_win_nxt;
    logic [IW-1:0]   r_last, w_last_nxt;

    logic            w_any;
    logic [IW-1:0]   w_pick;

    // Walk from the farthest candidate back to last+1 so the nearest wins.
    always_comb begin
        int idx;
        w_any  = 1'b0;
        w_pick = '0;
        idx    = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(r_last) + k) % NREQ;
            if (bus.req[IW'(idx)]) begin
                w_any  = 1'b1;
                w_pick = IW'(idx);
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_done_nxt   = '0;
        w_cnt_nxt    = r_cnt;
        w_target_nxt = r_target;
        w_win_nxt    = r_win;
        w_last_nxt   = r_last;
        unique case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt  = S_RUN;
                    w_gnt_nxt    = C_ONE << w_pick;
                    w_cnt_nxt    = '0;
                    w_target_nxt = bus.len[w_pick*CW +: CW];
                    w_win_nxt    = w_pick;
                end
            end
            S_RUN: begin
                // An abandoned request wins over a coincident terminal count.
                if (!bus.req[r_win]) begin
                    w_state_nxt = S_IDLE;
                    w_gnt_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_last_nxt  = r_win;
                end else if (r_cnt == r_target) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = C_ONE << r_win;
                end else if (bus.tick_en) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
                w_cnt_nxt   = '0;
                w_last_nxt  = r_win;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_gnt    <= '0;
            r_done   <= '0;
            r_cnt    <= '0;
            r_target <= '0;
            r_win    <= '0;
            r_last   <= IW'(NREQ - 1);
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_done   <= w_done_nxt;
            r_cnt    <= w_cnt_nxt;
            r_target <= w_target_nxt;
            r_win    <= w_win_nxt;
            r_last   <= w_last_nxt;
        end
    end

    assign bus.gnt   = r_gnt;
    assign bus.done  = r_done;
    assign bus.busy  = (r_state != S_IDLE);
    assign bus.cnt_q = r_cnt;
endmodule
`default_nettype wire

// File: doc/counter_timeslot_arbiter.md
Name: counter_timeslot_arbiter

Overview:
- Shares one CW-bit up-counter between NREQ requesters, each needing a delay of a programmable number of ticks.
- Arbitrates round-robin, loads the winner's length, runs the counter on tick_en and returns a one-cycle done pulse to the winner.
- Sits between control FSMs that need short timed waits and the shared counter resource, so each client does not need its own counter.

Parameters:
- NREQ, 4, number of requesters (2..8)
- CW, 4, counter and length width in bits

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- req  input  NREQ  request per client; held high until done or abandoned
- len  input  NREQ*CW  per-client tick count, client i at bits [i*CW +: CW]; sampled at grant
- tick_en  input  1  count enable (prescaler strobe); counter advances only when high
- gnt  output  NREQ  one-hot grant, registered
- done  output  NREQ  one-hot one-cycle completion pulse, registered
- busy  output  1  high in RUN or DONE
- cnt_q  output  CW  current shared counter value, registered

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; gnt=0, done=0, busy=0, cnt_q=0; last-winner pointer=NREQ-1, so client 0 has highest priority first. Reset overrides everything, including mid-RUN: the grant drops and no done pulse is issued.
- States: IDLE, RUN, DONE.
- IDLE:
  - If req != 0, pick the first set req bit searching last+1, last+2, ... modulo NREQ.
  - Next cycle: state=RUN, gnt=onehot(winner), cnt_q=0, target=len[winner], busy=1.
  - If req == 0, stay in IDLE.
- RUN:
  - If req[winner] deasserts: abort. Next cycle state=IDLE, gnt=0, busy=0, cnt_q=0, no done pulse, pointer=winner.
  - Else if cnt_q == target: next state DONE.
  - Else if tick_en: cnt_q <= cnt_q+1.
  - Else hold.
  - Abort has priority over the cnt_q==target check.
- DONE (exactly one cycle):
  - done[winner]=1; gnt stays asserted; cnt_q holds target.
  - Next cycle: state=IDLE, gnt=0, done=0, busy=0, cnt_q=0, pointer=winner.
- len=0: one RUN cycle, then DONE; tick_en is ignored.
- Counter never wraps: it stops at target, and the maximum target is 2^CW-1.
- len is sampled only on the IDLE->RUN edge. Later changes to len do not affect the running slot.
- Requests arriving during RUN/DONE wait; they are arbitrated on the next IDLE cycle.
- A winner still requesting after its done pulse is re-eligible, but it is lowest priority.
- Timing with tick_en constantly 1 and length L, req seen in IDLE at cycle 0:
  - gnt at cycle 1
  - cnt_q=L at cycle 1+L
  - done at cycle 2+L
  - IDLE at cycle 3+L
  - earliest next grant at cycle 4+L
- Invariants: gnt and done are each zero or one-hot; done[i] implies gnt[i] in the same cycle; busy == |gnt.

Test Plan:
- Reset, then req=0001, len0=3, tick_en=1 -> gnt=0001 at cycle 1; cnt_q 0,1,2,3 on cycles 1-4; done=0001 at cycle 5; gnt=0 at cycle 6.
- req=1111, all len=1, held -> grant order 0,1,2,3,0; each done pulse lasts exactly one cycle; never two gnt bits set.
- req0 with len0=2, tick_en toggling 1,0,1,0 -> cnt_q advances only on tick_en=1 cycles; done after 2 effective ticks, i.e. 4 RUN cycles plus 1.
- req2 with len2=0 -> gnt=0100 one cycle, done=0100 the next cycle, with cnt_q=0 throughout.
- req1 with len1=5; drop req1 when cnt_q=2 -> state IDLE next cycle, no done pulse; pending req3 is granted next, ahead of req1.
- rst asserted mid-RUN with cnt_q=4 -> next cycle gnt=0, done=0, cnt_q=0, busy=0; afterwards client 0 wins first again.
